// File: rtl/uart_cfg_pkg.sv
// Shared types and defaults for the DRSSTC configuration UART loader.
// UART_CFG_PARITY_EN adds the PARITY receiver state.
package uart_cfg_pkg;

   localparam int UART_CLKS_PER_BIT = 104;
   localparam int UART_PAR_NUM      = 5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
`ifdef UART_CFG_PARITY_EN
      ST_PARITY = 3'd5,
`endif
      ST_BREAK  = 3'd4
   } uart_rx_state_t;

   // Register indices as seen by the consuming blocks; the first byte of a
   // packet lands in the highest index.
   typedef enum logic [2:0] {
      REF_GEN     = 3'd0,
      PHASE_SHIFT = 3'd1,
      OCD_LVL     = 3'd2,
      INTER_FREQ  = 3'd3,
      INTER_DUTY  = 3'd4
   } Conf_par;

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchroniser for the raw UART pin plus a registered falling-edge
// detector; line and fall leave with the same latency so samples line up.
module uart_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic line,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic dly_q,  dly_d;
   logic fall_q, fall_d;

   always_comb begin
      meta_d = din;
      sync_d = meta_q;
      dly_d  = sync_q;
      fall_d = dly_q & ~sync_q;
   end

   // Idle-high reset keeps a quiet line from looking like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         dly_q  <= 1'b1;
         fall_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         dly_q  <= dly_d;
         fall_q <= fall_d;
      end
   end

   assign line = dly_q;
   assign fall = fall_q;

endmodule

// File: rtl/uart_cfg_rx.sv
// UART receiver loading a packet of PAR_NUM frames into a parameter bank.
// Define UART_CFG_PARITY_EN for an even-parity bit after the data bits.
module uart_cfg_rx
   import uart_cfg_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int DATA_BITS    = 8,
   parameter int PAR_NUM      = UART_PAR_NUM,
   parameter int GAP_CLKS     = 20 * 104
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              uart_data,
   output logic [PAR_NUM-1:0][DATA_BITS-1:0] params,
   output logic [PAR_NUM-1:0]                par_upd,
   output logic                              pkt_done,
   output logic                              frame_err,
   output logic                              busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = $clog2(DATA_BITS + 1);
   localparam int IDX_W = (PAR_NUM > 1) ? $clog2(PAR_NUM) : 1;
   localparam int GAP_W = $clog2(GAP_CLKS + 1);

   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
   localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(PAR_NUM - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(GAP_CLKS);
   localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);

   logic line_s;
   logic line_fall;

   uart_sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (uart_data),
      .line  (line_s),
      .fall  (line_fall)
   );

   uart_rx_state_t                    state_q,     state_d;
   logic [CNT_W-1:0]                  bit_cnt_q,   bit_cnt_d;
   logic [BIT_W-1:0]                  bit_idx_q,   bit_idx_d;
   logic [DATA_BITS-1:0]              shift_q,     shift_d;
   logic [IDX_W-1:0]                  idx_q,       idx_d;
   logic [GAP_W-1:0]                  gap_q,       gap_d;
   logic [PAR_NUM-1:0][DATA_BITS-1:0] params_q,    params_d;
   logic [PAR_NUM-1:0]                par_upd_q,   par_upd_d;
   logic                              pkt_done_q,  pkt_done_d;
   logic                              frame_err_q, frame_err_d;
`ifdef UART_CFG_PARITY_EN
   logic                              par_err_q,   par_err_d;
`endif

   logic bit_done;
   logic frame_ok;

   assign bit_done = (bit_cnt_q == '0);

`ifdef UART_CFG_PARITY_EN
   assign frame_ok = line_s & ~par_err_q;
`else
   assign frame_ok = line_s;
`endif

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      idx_d       = idx_q;
      gap_d       = '0;
      params_d    = params_q;
      par_upd_d   = '0;
      pkt_done_d  = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_CFG_PARITY_EN
      par_err_d   = par_err_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (line_fall) begin
               state_d   = ST_START;
               bit_cnt_d = HALF_LOAD;
            end else begin
               gap_d = (gap_q == GAP_MAX) ? gap_q : gap_q + GAP_ONE;
               // A long quiet line abandons a partial packet.
               if ((gap_q == GAP_MAX) && (idx_q != IDX_TOP)) begin
                  idx_d = IDX_TOP;
               end
            end
         end

         ST_START: begin
            if (bit_done) begin
               if (line_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_DATA;
                  bit_cnt_d = BIT_LOAD;
                  bit_idx_d = '0;
`ifdef UART_CFG_PARITY_EN
                  par_err_d = 1'b0;
`endif
               end
            end else begin
               bit_cnt_d = bit_cnt_q - CNT_ONE;
            end
         end

         ST_DATA: begin
            if (bit_done) begin
               shift_d   = {line_s, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = BIT_LOAD;
               bit_idx_d = bit_idx_q + BIT_ONE;
               if (bit_idx_q == LAST_BIT) begin
`ifdef UART_CFG_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end else begin
               bit_cnt_d = bit_cnt_q - CNT_ONE;
            end
         end

`ifdef UART_CFG_PARITY_EN
         ST_PARITY: begin
            if (bit_done) begin
               par_err_d = ^{shift_q, line_s};
               bit_cnt_d = BIT_LOAD;
               state_d   = ST_STOP;
            end else begin
               bit_cnt_d = bit_cnt_q - CNT_ONE;
            end
         end
`endif

         ST_STOP: begin
            if (bit_done) begin
               if (frame_ok) begin
                  state_d            = ST_IDLE;
                  params_d[idx_q]    = shift_q;
                  par_upd_d[idx_q]   = 1'b1;
                  if (idx_q == '0) begin
                     pkt_done_d = 1'b1;
                     idx_d      = IDX_TOP;
                  end else begin
                     idx_d = idx_q - IDX_ONE;
                  end
               end else begin
                  state_d     = ST_BREAK;
                  frame_err_d = 1'b1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q - CNT_ONE;
            end
         end

         // A line held low must return high before any new start edge counts.
         ST_BREAK: begin
            if (line_s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         idx_q       <= IDX_TOP;
         gap_q       <= '0;
         params_q    <= '0;
         par_upd_q   <= '0;
         pkt_done_q  <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_CFG_PARITY_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         idx_q       <= idx_d;
         gap_q       <= gap_d;
         params_q    <= params_d;
         par_upd_q   <= par_upd_d;
         pkt_done_q  <= pkt_done_d;
         frame_err_q <= frame_err_d;
`ifdef UART_CFG_PARITY_EN
         par_err_q   <= par_err_d;
`endif
      end
   end

   assign params    = params_q;
   assign par_upd   = par_upd_q;
   assign pkt_done  = pkt_done_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cfg_rx.sv
// Directed bench for uart_cfg_rx: frame table plus glitch and mid-frame reset.
// Parity vectors are added when UART_CFG_PARITY_EN is defined.
module tb_uart_cfg_rx;

   localparam int CPB = 104;
   localparam int DW  = 8;
   localparam int PN  = 5;
   localparam int GAP = 20 * 104;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   uart_data = 1'b1;
   logic [PN-1:0][DW-1:0]  params;
   logic [PN-1:0]          par_upd;
   logic                   pkt_done;
   logic                   frame_err;
   logic                   busy;

   always #5 clk = ~clk;

   uart_cfg_rx #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DW),
      .PAR_NUM      (PN),
      .GAP_CLKS     (GAP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .uart_data (uart_data),
      .params    (params),
      .par_upd   (par_upd),
      .pkt_done  (pkt_done),
      .frame_err (frame_err),
      .busy      (busy)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          stop;
      logic          par_flip;
      int            idle_after;
      logic [PN-1:0] exp_upd;
      logic          exp_pkt;
      logic          exp_ferr;
   } vec_t;

   vec_t                  vecs[$];
   logic [PN-1:0][DW-1:0] exp_params = '0;
   int                    n_cmp  = 0;
   int                    n_fail = 0;

   int                    upd_total  = 0;
   int                    pkt_total  = 0;
   int                    ferr_total = 0;
   logic [PN-1:0]         last_upd   = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (par_upd != '0) begin
            upd_total = upd_total + 1;
            last_upd  = par_upd;
         end
         if (pkt_done)  pkt_total  = pkt_total + 1;
         if (frame_err) ferr_total = ferr_total + 1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [DW-1:0] data, input logic stop, input logic par_flip,
                          input int idle_after, input logic [PN-1:0] exp_upd,
                          input logic exp_pkt, input logic exp_ferr);
      vec_t v;
      v.data = data; v.stop = stop; v.par_flip = par_flip; v.idle_after = idle_after;
      v.exp_upd = exp_upd; v.exp_pkt = exp_pkt; v.exp_ferr = exp_ferr;
      vecs.push_back(v);
   endtask

   task automatic send_frame(input logic [DW-1:0] data, input logic stop, input logic par_flip);
      uart_data = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < DW; i++) begin
         uart_data = data[i];
         repeat (CPB) @(posedge clk);
      end
`ifdef UART_CFG_PARITY_EN
      uart_data = (^data) ^ par_flip;
      repeat (CPB) @(posedge clk);
`else
      if (par_flip) $display("note: parity flip ignored without parity");
`endif
      uart_data = stop;
      repeat (CPB) @(posedge clk);
      uart_data = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int u0, p0, f0;
      u0 = upd_total; p0 = pkt_total; f0 = ferr_total;
      send_frame(v.data, v.stop, v.par_flip);
      repeat (20 + v.idle_after) @(posedge clk);
      @(negedge clk);
      #1;
      for (int k = 0; k < PN; k++) begin
         if (v.exp_upd[k]) exp_params[k] = v.data;
      end
      check({tag, " upd_cnt"}, 64'(upd_total - u0), (v.exp_upd != '0) ? 64'd1 : 64'd0);
      if (v.exp_upd != '0) check({tag, " upd_val"}, 64'(last_upd), 64'(v.exp_upd));
      check({tag, " pkt_done"}, 64'(pkt_total - p0), 64'(v.exp_pkt));
      check({tag, " frame_err"}, 64'(ferr_total - f0), 64'(v.exp_ferr));
      check({tag, " params"}, 64'(params), 64'(exp_params));
   endtask

   initial begin
      vec_t rv;
      int   busy_cnt;
      int   u0, f0;

      //      data   stop  flip idle  upd    pkt   ferr
      add_vec(8'h11, 1'b1, 1'b0, 0,    5'h10, 1'b0, 1'b0);
      add_vec(8'h22, 1'b1, 1'b0, 0,    5'h08, 1'b0, 1'b0);
      add_vec(8'h33, 1'b1, 1'b0, 0,    5'h04, 1'b0, 1'b0);
      add_vec(8'h44, 1'b1, 1'b0, 0,    5'h02, 1'b0, 1'b0);
      add_vec(8'h55, 1'b1, 1'b0, 0,    5'h01, 1'b1, 1'b0);
      add_vec(8'hA5, 1'b0, 1'b0, 0,    5'h00, 1'b0, 1'b1);
      add_vec(8'h5A, 1'b1, 1'b0, 2200, 5'h10, 1'b0, 1'b0);
      add_vec(8'h01, 1'b1, 1'b0, 0,    5'h10, 1'b0, 1'b0);
      add_vec(8'h02, 1'b1, 1'b0, 2200, 5'h08, 1'b0, 1'b0);
      add_vec(8'h77, 1'b1, 1'b0, 2200, 5'h10, 1'b0, 1'b0);
`ifdef UART_CFG_PARITY_EN
      add_vec(8'h03, 1'b1, 1'b1, 0,    5'h00, 1'b0, 1'b1);
      add_vec(8'h03, 1'b1, 1'b0, 0,    5'h10, 1'b0, 1'b0);
`endif

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst params", 64'(params), 64'd0);
      check("rst par_upd", 64'(par_upd), 64'd0);
      check("rst pkt_done", 64'(pkt_done), 64'd0);
      check("rst frame_err", 64'(frame_err), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // 30-cycle low glitch: START lasts exactly half a bit, then back to IDLE.
      u0 = upd_total; f0 = ferr_total; busy_cnt = 0;
      @(posedge clk);
      uart_data = 1'b0;
      for (int c = 0; c < 120; c++) begin
         @(posedge clk);
         if (c == 29) uart_data = 1'b1;
         @(negedge clk);
         if (busy) busy_cnt = busy_cnt + 1;
      end
      check("glitch busy_cycles", 64'(busy_cnt), 64'd52);
      check("glitch busy_end", 64'(busy), 64'd0);
      check("glitch no_write", 64'(upd_total - u0), 64'd0);
      check("glitch no_ferr", 64'(ferr_total - f0), 64'd0);
      check("glitch params", 64'(params), 64'(exp_params));

      // Reset pulled mid-way through data bit 3 of a frame.
      @(posedge clk);
      uart_data = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         uart_data = i[0];
         repeat (CPB) @(posedge clk);
      end
      uart_data = 1'b1;
      repeat (CPB / 2) @(posedge clk);
      check("pre_rst busy", 64'(busy), 64'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst params", 64'(params), 64'd0);
      check("async_rst par_upd", 64'(par_upd), 64'd0);
      check("async_rst pkt_done", 64'(pkt_done), 64'd0);
      check("async_rst frame_err", 64'(frame_err), 64'd0);
      check("async_rst busy", 64'(busy), 64'd0);
      exp_params = '0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      rv.data = 8'h3C; rv.stop = 1'b1; rv.par_flip = 1'b0; rv.idle_after = 0;
      rv.exp_upd = 5'h10; rv.exp_pkt = 1'b0; rv.exp_ferr = 1'b0;
      run_vec(rv, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_cfg_rx.md
# uart_cfg_rx

Parametrised UART receiver that loads a packet of configuration bytes into a bank of parameter registers for the DRSSTC controller (reference generator, phase shift, OCD level, interrupter frequency/duty and future additions). It generalises the fixed 8N1, 5-parameter loader: baud, data width and parameter count are parameters. It adds start-bit validation, stop-bit checking and inter-packet gap resynchronisation, with optional parity. It sits between the board UART pin and every block that consumes a configuration parameter.

## Interface
- `CLKS_PER_BIT`, 104: clk cycles per UART bit; must be ≥ 4.
- `DATA_BITS`, 8: data bits per frame, LSB first; range 5–16.
- `PAR_NUM`, 5: number of parameter registers, which is also the packet length in frames; must be ≥ 1.
- `GAP_CLKS`, 20*104: idle clocks, counted from the last stop-bit sample, after which the packet index resynchronises.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `uart_data`  in  1  asynchronous serial line; idles high.
- `params`  out  [PAR_NUM] x DATA_BITS  parameter bank; reset value 0.
- `par_upd`  out  PAR_NUM  one-hot, one-cycle pulse marking the written register; reset 0.
- `pkt_done`  out  1  one-cycle pulse when index 0 is written; reset 0.
- `frame_err`  out  1  one-cycle pulse on a stop-bit or parity error; reset 0.
- `busy`  out  1  high in every state except IDLE; reset 0.

## Operation
- `uart_data` passes through a 2-FF synchroniser (reset value 1), then a falling-edge detector.
- State machine states: IDLE, START, DATA, PARITY (only with the macro), STOP, BREAK.
- IDLE
  - A falling edge moves to START and loads bit_cnt = CLKS_PER_BIT/2 − 1.
- START
  - When bit_cnt reaches 0, sample the line.
  - Sample 1: false start, return to IDLE. No outputs change.
  - Sample 0: go to DATA, load CLKS_PER_BIT − 1, clear the bit index.
- DATA
  - Each time bit_cnt reaches 0, shift the sample in at the MSB (LSB-first reception) and reload bit_cnt.
  - After DATA_BITS samples, go to PARITY or STOP.
- PARITY
  - Sample one bit. Even parity is required over the data bits plus the parity bit.
  - On a mismatch, latch a parity-error flag for this frame.
- STOP
  - Sample the stop bit at its mid-point.
  - Sample 1 and no parity error: write the byte to `params[idx]`, pulse `par_upd[idx]` and go to IDLE.
  - Otherwise: pulse `frame_err`, discard the byte, leave `idx` unchanged and go to BREAK.
- BREAK
  - Wait for the synchronised line to be high, then go to IDLE. A held-low line therefore never produces frames.
- Packet index `idx`
  - Resets to PAR_NUM − 1.
  - Decrements after each good frame. The first byte of a packet lands in the highest index.
  - At 0, a good frame pulses `pkt_done` and wraps `idx` to PAR_NUM − 1.
- Gap counter
  - Runs in IDLE, saturates at GAP_CLKS and clears on leaving IDLE.
  - On reaching GAP_CLKS with idx ≠ PAR_NUM − 1, idx returns to PAR_NUM − 1. A partial packet is abandoned and registers already written keep their new values.
- Widths
  - bit_cnt is $clog2(CLKS_PER_BIT).
  - The bit index is $clog2(DATA_BITS+1).
  - idx is $clog2(PAR_NUM), minimum 1 bit.
  - The gap counter is $clog2(GAP_CLKS+1).
  - All counters are unsigned and never wrap below 0.

## Timing
- Input latency: 2 clk cycles of synchroniser plus 1 for the edge detector.
- A frame's sample points are at ½, 1½, … bit-times after the detected falling edge.
- `params[idx]`, `par_upd` and `pkt_done` all update on the same clock edge, registered from the STOP sample cycle.
- The next frame's start edge is accepted from the cycle after the STOP sample, so back-to-back frames with one stop bit are supported.
- Gap resync and a good STOP cannot coincide, because the gap counter only runs in IDLE.
- Mid-frame `rst_n` assertion immediately clears:
  - the state, counters and idx;
  - all `params`;
  - all pulses.
- Reset release is asynchronous assertion with release taken on the next clk edge. The first frame must begin at least 3 cycles after release.

## Configuration
- `UART_CFG_PARITY_EN`, defined: the PARITY state exists, frames are DATA_BITS + 1 even-parity bit, and a parity error raises `frame_err` and discards the byte.
- Undefined: no parity bit and no PARITY state. Frames are start + DATA_BITS + stop.

## Structure
- Shared package `uart_cfg_pkg`:
  - `uart_rx_state_t` enum;
  - `Conf_par` enum naming parameter indices (REF_GEN = 0, PHASE_SHIFT, OCD_LVL, INTER_FREQ, INTER_DUTY);
  - default constants `UART_CLKS_PER_BIT` = 104 and `UART_PAR_NUM` = 5.
- One sub-module, `uart_sync_edge`: 2-FF synchroniser plus falling-edge detector, with `clk`/`rst_n`.

## Test plan
- Reset, then bytes 0x11,0x22,0x33,0x44,0x55 at 104 clk/bit.
  - `params[4..0]` read 0x11..0x55.
  - `par_upd` pulses 0x10,0x08,0x04,0x02,0x01.
  - `pkt_done` pulses once after 0x55.
- Low glitch of 30 cycles on an idle line: no state beyond START, and `busy` returns low by cycle ~56.
- Byte 0xA5 with the stop bit forced 0: `frame_err` pulses, `params` unchanged, idx stays 4. Line high, then a good 0x5A: `params[4]` = 0x5A.
- Two bytes 0x01,0x02, then idle > GAP_CLKS, then 0x77: `params[4]` = 0x77, and `params[3]` = 0x02 is retained.
- `rst_n` pulsed low during data bit 3 of a frame: all outputs 0 in the same cycle, idx = 4, and the next full frame is received correctly.
- With `UART_CFG_PARITY_EN`, byte 0x03 with parity bit 1: `frame_err` pulses and no write occurs. With parity bit 0: written to `params[4]`.
